gray_code_counter: RTL and testbench

- Synchronous up/down counter whose state and output are held directly in reflected-binary Gray code.
- Sits directly upstream of the team's combinational Gray-to-binary converter and drives its Gray-code inputs.
- Exactly one output bit changes per count step, so the count can be sampled safely by a neighbouring stage.
- Supports parallel load of a Gray-coded value and a registered wrap indication.

---
 rtl/gray_code_counter.sv | 69 ++++++
 tb/tb_gray_code_counter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down counter that keeps its state in reflected-binary
// Gray code, so only one bit of g changes per step. The block also supports a
// parallel load of a Gray-coded value and gives a one-cycle registered wrap
// pulse. There is no valid/ready handshake: every input is sampled on each
// rising clock edge.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d_gray,
  output logic [WIDTH-1:0] g,
  output logic             wrap
);

  logic [WIDTH-1:0] r_g;
  logic             r_wrap;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_g_next;
  logic             w_wrap_hit;

  // Gray-to-binary conversion. Each binary bit is the XOR of all Gray bits at
  // or above it. This is the prefix form of b[i] = b[i+1] ^ g[i], written so
  // that no combinational signal depends on itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign w_bin[i] = ^r_g[WIDTH-1:i];
  end

  // Next binary value, its Gray re-encoding, and detection of the wrap
  // boundary for the selected direction.
  always_comb begin
    w_bin_next = w_bin;
    w_wrap_hit = 1'b0;
    if (up) begin
      w_bin_next = w_bin + WIDTH'(1);
      w_wrap_hit = &w_bin;
    end else begin
      w_bin_next = w_bin - WIDTH'(1);
      w_wrap_hit = ~|w_bin;
    end
    w_g_next = w_bin_next ^ (w_bin_next >> 1);
  end

  // State register. Priority is reset > load > enable > hold. The wrap output
  // is high only after a counting edge that crossed the boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_g    <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_g    <= d_gray;
      r_wrap <= 1'b0;
    end else if (enable) begin
      r_g    <= w_g_next;
      r_wrap <= w_wrap_hit;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign g    = r_g;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed testbench for gray_code_counter with WIDTH = 4. The expected values
// are worked out by hand. A reference decoder searches for the binary value
// that encodes to the observed g, and that value is compared with the count
// the bench expects.
module tb_gray_code_counter;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] d_gray;
  logic [W-1:0] g;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] g_prev;

  gray_code_counter #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .up     (up),
    .load   (load),
    .d_gray (d_gray),
    .g      (g),
    .wrap   (wrap)
  );

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog that stops a runaway simulation
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Single comparison point
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: finds the binary value k whose Gray encoding is gv
  function automatic logic [W-1:0] gray_to_bin_ref(input logic [W-1:0] gv);
    logic [W-1:0] k;
    gray_to_bin_ref = '0;
    for (int n = 0; n < (1 << W); n++) begin
      k = W'(n);
      if ((k ^ (k >> 1)) == gv) gray_to_bin_ref = k;
    end
  endfunction

  // Drives one clock cycle of inputs, then samples 1 time unit after the edge
  task automatic step(input logic en, input logic u, input logic ld, input logic [W-1:0] d);
    enable = en;
    up     = u;
    load   = ld;
    d_gray = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [W-1:0] up_tbl[16];
    logic [W-1:0] dn_tbl[4];
    logic [W-1:0] e;
    up_tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    dn_tbl = '{4'b1000, 4'b1001, 4'b1011, 4'b1010};

    // Reset: the outputs must be cleared before any clock edge
    reset = 1'b1; enable = 1'b0; up = 1'b0; load = 1'b0; d_gray = '0;
    #1;
    check("reset_async_g", 16'(g), 16'h0);
    check("reset_async_wrap", 16'(wrap), 16'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_g", 16'(g), 16'h0);

    // Full up-count sweep, including the downstream decode of each value
    for (int i = 0; i < 16; i++) exp_q.push_back(up_tbl[i]);
    for (int i = 0; i < 16; i++) begin
      g_prev = g;
      step(1'b1, 1'b1, 1'b0, '0);
      e = exp_q.pop_front();
      check($sformatf("up_g[%0d]", i), 16'(g), 16'(e));
      check($sformatf("up_wrap[%0d]", i), 16'(wrap), (i == 15) ? 16'h1 : 16'h0);
      check($sformatf("up_onebit[%0d]", i), 16'($countones(g_prev ^ g)), 16'h1);
      check($sformatf("up_bin[%0d]", i), 16'(gray_to_bin_ref(g)), 16'((i + 1) % 16));
    end

    // Down-count from zero: wraps 0000 -> 1000, then continues downward
    for (int i = 0; i < 4; i++) begin
      g_prev = g;
      step(1'b1, 1'b0, 1'b0, '0);
      check($sformatf("dn_g[%0d]", i), 16'(g), 16'(dn_tbl[i]));
      check($sformatf("dn_wrap[%0d]", i), 16'(wrap), (i == 0) ? 16'h1 : 16'h0);
      check($sformatf("dn_onebit[%0d]", i), 16'($countones(g_prev ^ g)), 16'h1);
    end

    // Load has priority over enable
    step(1'b0, 1'b0, 1'b1, 4'b0011);
    check("load_setup", 16'(g), 16'b0011);
    step(1'b1, 1'b1, 1'b1, 4'b1010);
    check("load_prio_g", 16'(g), 16'b1010);
    check("load_prio_wrap", 16'(wrap), 16'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("after_load_g", 16'(g), 16'b1011);

    // Hold for three cycles, then toggle direction
    step(1'b0, 1'b0, 1'b1, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check($sformatf("hold_g[%0d]", i), 16'(g), 16'b0110);
      check($sformatf("hold_wrap[%0d]", i), 16'(wrap), 16'h0);
    end
    step(1'b1, 1'b1, 1'b0, '0);
    check("dir_up1", 16'(g), 16'b0111);
    step(1'b1, 1'b1, 1'b0, '0);
    check("dir_up2", 16'(g), 16'b0101);
    step(1'b1, 1'b0, 1'b0, '0);
    check("dir_dn", 16'(g), 16'b0111);

    // Reset asserted in the middle of a count, between clock edges
    step(1'b0, 1'b1, 1'b1, 4'b1100);
    step(1'b1, 1'b1, 1'b0, '0);
    check("mid_pre_g", 16'(g), 16'b1101);
    #3 reset = 1'b1;
    #1;
    check("mid_reset_g", 16'(g), 16'h0);
    check("mid_reset_wrap", 16'(wrap), 16'h0);
    #1 reset = 1'b0;
    step(1'b1, 1'b1, 1'b0, '0);
    check("post_reset_g", 16'(g), 16'b0001);

    // Async reset clears a pending wrap pulse
    step(1'b0, 1'b1, 1'b1, 4'b1000);
    step(1'b1, 1'b1, 1'b0, '0);
    check("wrap_pre", 16'(wrap), 16'h1);
    #3 reset = 1'b1;
    #1;
    check("wrap_async_clear", 16'(wrap), 16'h0);
    #1 reset = 1'b0;

    // Down wrap followed by a hold: the pulse lasts a single cycle
    step(1'b1, 1'b0, 1'b0, '0);
    check("dn_wrap_g", 16'(g), 16'b1000);
    check("dn_wrap_pulse", 16'(wrap), 16'h1);
    step(1'b0, 1'b0, 1'b0, '0);
    check("dn_wrap_hold_g", 16'(g), 16'b1000);
    check("dn_wrap_drop", 16'(wrap), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
